// File: rtl/led_pkg.sv
// Shared types and default timing for the WS2812 strip driver.
// GRB packing puts green in the MSBs because green is shifted out first.
package led_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT,
        LOAD,
        SEND
    } state_e;

    localparam int COLOR_BITS = 24;
    localparam int DEF_T0H    = 40;
    localparam int DEF_T1H    = 80;
    localparam int DEF_BIT    = 125;
    localparam int DEF_RESET  = 6000;

    function automatic logic [COLOR_BITS-1:0] pack_grb(
        input logic [7:0] g,
        input logic [7:0] r,
        input logic [7:0] b
    );
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shapes one WS2812 bit: high for T0H/T1H cycles, low for the rest.
// bit_done_o flags the final cycle so the next bit can start seamlessly.
module ws2812_bit_encoder #(
    parameter int T0H_CYCLES = 40,
    parameter int T1H_CYCLES = 80,
    parameter int BIT_CYCLES = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic bit_i,
    output logic line_o,
    output logic bit_done_o
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          bit_q;
    logic          active_q;
    logic          line_q;

    function automatic logic high(input logic b, input logic [CW-1:0] c);
        return int'(c) < (b ? T1H_CYCLES : T0H_CYCLES);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            line_q   <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= '0;
            bit_q    <= bit_i;
            active_q <= 1'b1;
            line_q   <= high(bit_i, '0);
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
                line_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                line_q <= high(bit_q, cnt_q + 1'b1);
            end
        end
    end

    assign line_o     = line_q;
    assign bit_done_o = active_q && (cnt_q == LAST);

endmodule

// File: rtl/ws2812_strip_driver.sv
// Frame sequencer: latch period, then per-LED load and 24-bit GRB send.
// The request output is advanced at LOAD so the source has a full LED time to settle.
module ws2812_strip_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 6,
    parameter int T0H_CYCLES        = DEF_T0H,
    parameter int T1H_CYCLES        = DEF_T1H,
    parameter int BIT_CYCLES        = DEF_BIT,
    parameter int RESET_CYCLES      = DEF_RESET
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
    output logic                         data_out,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] LED_LAST = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
    localparam logic [4:0] BIT_LAST = 5'(COLOR_BITS - 1);

    if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
        $error("ws2812_strip_driver: need T0H < T1H < BIT");
    end
    if (LED_ADDRESS_WIDTH < $clog2(NUM_LEDS)) begin : g_bad_width
        $error("ws2812_strip_driver: LED_ADDRESS_WIDTH too small");
    end

    state_e                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [LED_ADDRESS_WIDTH-1:0]   led_q;
    logic [4:0]                     bidx_q;
    logic [COLOR_BITS-2:0]          shift_q;
    logic [LED_ADDRESS_WIDTH-1:0]   req_q;
    logic                           fd_q;
    logic                           busy_q;

    logic [COLOR_BITS-1:0] grb;
    logic                  start;
    logic                  enc_bit;
    logic                  line;
    logic                  bit_done;

    // MSB is fed straight to the encoder at LOAD; only the remaining bits are kept.
    always_comb begin
        grb     = pack_grb(green_in, red_in, blue_in);
        start   = 1'b0;
        enc_bit = shift_q[COLOR_BITS-2];
        if (state_q == LOAD) begin
            enc_bit = grb[COLOR_BITS-1];
            start   = color_valid;
        end else if (state_q == SEND && bit_done && bidx_q != BIT_LAST) begin
            start = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_WAIT;
            cnt_q   <= '0;
            led_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            req_q   <= '0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            unique case (state_q)
                RESET_WAIT: begin
                    req_q <= '0;
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (color_valid) begin
                        shift_q <= grb[COLOR_BITS-2:0];
                        req_q   <= (led_q == LED_LAST) ? '0 : led_q + 1'b1;
                        bidx_q  <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bit_done) begin
                        if (bidx_q == BIT_LAST) begin
                            bidx_q <= '0;
                            if (led_q == LED_LAST) begin
                                fd_q    <= 1'b1;
                                led_q   <= '0;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                                state_q <= RESET_WAIT;
                            end else begin
                                led_q   <= led_q + 1'b1;
                                state_q <= LOAD;
                            end
                        end else begin
                            shift_q <= {shift_q[COLOR_BITS-3:0], 1'b0};
                            bidx_q  <= bidx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= RESET_WAIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    ws2812_bit_encoder #(
        .T0H_CYCLES(T0H_CYCLES),
        .T1H_CYCLES(T1H_CYCLES),
        .BIT_CYCLES(BIT_CYCLES)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .bit_i     (enc_bit),
        .line_o    (line),
        .bit_done_o(bit_done)
    );

    assign data_out         = line;
    assign next_led_request = req_q;
    assign frame_done       = fd_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for ws2812_strip_driver with a 3-LED strip and short timing.
// Each task resets the DUT and checks one behaviour against hand-derived values.
module tb_ws2812_strip_driver;

    localparam int NL   = 3;
    localparam int AW   = 6;
    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int BITC = 6;
    localparam int RSTC = 10;

    logic          clk;
    logic          rst;
    logic [7:0]    g, r, b;
    logic          cv;
    logic [AW-1:0] req;
    logic          dout;
    logic          fd;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    int          cap_hi[24];
    logic [23:0] cap_val;
    logic        cap_shape;

    ws2812_strip_driver #(
        .NUM_LEDS         (NL),
        .LED_ADDRESS_WIDTH(AW),
        .T0H_CYCLES       (T0H),
        .T1H_CYCLES       (T1H),
        .BIT_CYCLES       (BITC),
        .RESET_CYCLES     (RSTC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .green_in        (g),
        .red_in          (r),
        .blue_in         (b),
        .color_valid     (cv),
        .next_led_request(req),
        .data_out        (dout),
        .frame_done      (fd),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts low, not-busy cycles from the current negedge until busy rises.
    task automatic count_low(output int n, output logic seen_high);
        n = 0;
        seen_high = 1'b0;
        while (busy !== 1'b1 && n < 50) begin
            if (dout !== 1'b0) seen_high = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    // Samples 24 bit periods starting at the current negedge (bit 0, cycle 0).
    task automatic capture_led();
        cap_shape = 1'b1;
        cap_val = '0;
        for (int i = 0; i < 24; i++) begin
            cap_hi[i] = 0;
            for (int c = 0; c < BITC; c++) begin
                if (dout === 1'b1) begin
                    if (cap_hi[i] != c) cap_shape = 1'b0;
                    cap_hi[i]++;
                end else if (dout !== 1'b0) begin
                    cap_shape = 1'b0;
                end
                @(negedge clk);
            end
            if (cap_hi[i] != T0H && cap_hi[i] != T1H) cap_shape = 1'b0;
            cap_val[23-i] = (cap_hi[i] == T1H);
        end
    endtask

    task automatic test_reset();
        int n;
        logic h;
        g = 8'h11; r = 8'h22; b = 8'h33; cv = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data_out: got %b expected 0", dout);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (req !== '0) begin
            n_errors++;
            $display("FAIL reset_request: got %0d expected 0", req);
        end
        n_checks++;
        if (fd !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_frame_done: got %b expected 0", fd);
        end
        rst = 1'b0;
        count_low(n, h);
        n_checks++;
        if (n != RSTC) begin
            n_errors++;
            $display("FAIL reset_latch_len: got %0d cycles expected %0d", n, RSTC);
        end
        n_checks++;
        if (h !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_latch_low: line went high got %b expected 0", h);
        end
        n_checks++;
        if (req !== '0 || dout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_first_load: got req=%0d dout=%b expected 0/0", req, dout);
        end
        @(negedge clk);
        n_checks++;
        if (req !== 6'd1) begin
            n_errors++;
            $display("FAIL reset_first_advance: got %0d expected 1", req);
        end
    endtask

    task automatic test_waveform();
        int n;
        logic h;
        logic [23:0] pat;
        int exp;
        pat = 24'hA500FF;
        g = 8'hA5; r = 8'h00; b = 8'hFF; cv = 1'b1;
        pulse_reset();
        count_low(n, h);
        @(negedge clk);
        capture_led();
        for (int i = 0; i < 24; i++) begin
            exp = pat[23-i] ? T1H : T0H;
            n_checks++;
            if (cap_hi[i] != exp) begin
                n_errors++;
                $display("FAIL wave_bit%0d_high: got %0d cycles expected %0d", i, cap_hi[i], exp);
            end
        end
        n_checks++;
        if (cap_shape !== 1'b1) begin
            n_errors++;
            $display("FAIL wave_shape: got %b expected 1", cap_shape);
        end
        n_checks++;
        if (dout !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wave_gap_cycle: got dout=%b busy=%b expected 0/1", dout, busy);
        end
    endtask

    task automatic test_request_sequence();
        int n;
        logic h;
        int fd_cnt;
        int fd_t;
        logic bad_rw;
        logic busy_end;
        int exp;
        g = 8'h12; r = 8'h34; b = 8'h56; cv = 1'b1;
        pulse_reset();
        count_low(n, h);
        fd_cnt = 0;
        fd_t = -1;
        bad_rw = 1'b0;
        busy_end = 1'b0;
        for (int t = 0; t <= 445; t++) begin
            if (t == 0 || t == 1 || t == 145 || t == 146 || t == 290 || t == 291) begin
                exp = (t < 1) ? 0 : (t < 146) ? 1 : (t < 291) ? 2 : 0;
                n_checks++;
                if (req !== AW'(exp)) begin
                    n_errors++;
                    $display("FAIL req_t%0d: got %0d expected %0d", t, req, exp);
                end
            end
            if (fd === 1'b1) begin
                fd_cnt++;
                fd_t = t;
            end
            if (t >= 435 && t <= 444 && (dout !== 1'b0 || busy !== 1'b0)) bad_rw = 1'b1;
            if (t == 445) busy_end = busy;
            @(negedge clk);
        end
        n_checks++;
        if (fd_cnt != 1) begin
            n_errors++;
            $display("FAIL frame_done_count: got %0d expected 1", fd_cnt);
        end
        n_checks++;
        if (fd_t != 435) begin
            n_errors++;
            $display("FAIL frame_done_time: got %0d expected 435", fd_t);
        end
        n_checks++;
        if (bad_rw !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_latch_low: got %b expected 0", bad_rw);
        end
        n_checks++;
        if (busy_end !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_next_load: got busy=%b expected 1", busy_end);
        end
    endtask

    task automatic test_stall();
        int n;
        logic h;
        logic bad;
        g = 8'hC3; r = 8'h5A; b = 8'h0F; cv = 1'b0;
        pulse_reset();
        count_low(n, h);
        n_checks++;
        if (n != RSTC) begin
            n_errors++;
            $display("FAIL stall_latch_len: got %0d expected %0d", n, RSTC);
        end
        bad = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (dout !== 1'b0 || req !== '0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold: got %b expected 0", bad);
        end
        n_checks++;
        if (dout !== 1'b0 || req !== '0) begin
            n_errors++;
            $display("FAIL stall_no_advance: got dout=%b req=%0d expected 0/0", dout, req);
        end
        cv = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dout !== 1'b1 || req !== 6'd1) begin
            n_errors++;
            $display("FAIL stall_release: got dout=%b req=%0d expected 1/1", dout, req);
        end
        capture_led();
        n_checks++;
        if (cap_val !== 24'hC35A0F || cap_shape !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_color: got %h shape=%b expected c35a0f/1", cap_val, cap_shape);
        end
    endtask

    task automatic test_midsend_change();
        int n;
        logic h;
        g = 8'h3C; r = 8'h81; b = 8'h5A; cv = 1'b1;
        pulse_reset();
        count_low(n, h);
        @(negedge clk);
        g = 8'hC3; r = 8'h7E; b = 8'hA5;
        capture_led();
        n_checks++;
        if (cap_val !== 24'h3C815A || cap_shape !== 1'b1) begin
            n_errors++;
            $display("FAIL midsend_latched: got %h shape=%b expected 3c815a/1", cap_val, cap_shape);
        end
        @(negedge clk);
        capture_led();
        n_checks++;
        if (cap_val !== 24'hC37EA5 || cap_shape !== 1'b1) begin
            n_errors++;
            $display("FAIL midsend_next_led: got %h shape=%b expected c37ea5/1", cap_val, cap_shape);
        end
    endtask

    task automatic test_reset_midhigh();
        int n;
        logic h;
        g = 8'hFF; r = 8'hFF; b = 8'hFF; cv = 1'b1;
        pulse_reset();
        count_low(n, h);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dout !== 1'b1) begin
            n_errors++;
            $display("FAIL midhigh_precond: got %b expected 1", dout);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dout !== 1'b0 || req !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midhigh_reset: got dout=%b req=%0d busy=%b expected 0/0/0", dout, req, busy);
        end
        rst = 1'b0;
        count_low(n, h);
        n_checks++;
        if (n != RSTC || h !== 1'b0) begin
            n_errors++;
            $display("FAIL midhigh_latch: got %0d cycles high=%b expected %0d/0", n, h, RSTC);
        end
        n_checks++;
        if (req !== '0) begin
            n_errors++;
            $display("FAIL midhigh_load_req: got %0d expected 0", req);
        end
        @(negedge clk);
        n_checks++;
        if (dout !== 1'b1 || req !== 6'd1) begin
            n_errors++;
            $display("FAIL midhigh_resend: got dout=%b req=%0d expected 1/1", dout, req);
        end
    endtask

    initial begin
        rst = 1'b1;
        g = '0; r = '0; b = '0; cv = 1'b0;
        test_reset();
        test_waveform();
        test_request_sequence();
        test_stall();
        test_midsend_change();
        test_reset_midhigh();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ws2812_strip_driver.md
Name: ws2812_strip_driver

Overview:
- Serializes per-LED colours onto a single WS2812-style data line, one frame per pass over all LEDs.
- Sits directly downstream of the colour sources (calibration ID display, pattern generators). It drives `next_led_request` to them and consumes their `green`/`red`/`blue`/`color_valid`.
- Each frame sends LEDs 0..NUM_LEDS-1, then holds the line low for the latch period. Frames repeat continuously.

Parameters:
- NUM_LEDS, 50, number of LEDs on the strip.
- LED_ADDRESS_WIDTH, 6, width of `next_led_request`; must be at least $clog2(NUM_LEDS).
- T0H_CYCLES, 40, high time of a 0 bit, in clk cycles.
- T1H_CYCLES, 80, high time of a 1 bit, in clk cycles.
- BIT_CYCLES, 125, total bit period, in clk cycles.
- RESET_CYCLES, 6000, low time that latches a frame, in clk cycles.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rst  in  1  synchronous, active-high reset.
- green_in  in  8  green byte for the currently requested LED.
- red_in  in  8  red byte for the currently requested LED.
- blue_in  in  8  blue byte for the currently requested LED.
- color_valid  in  1  colour inputs are valid for the current request.
- next_led_request  out  LED_ADDRESS_WIDTH  index of the LED whose colour is wanted next.
- data_out  out  1  serial line to the strip.
- frame_done  out  1  one-cycle pulse when the last bit of LED NUM_LEDS-1 completes.
- busy  out  1  high in LOAD and SEND, low in RESET_WAIT.

Behaviour:
- Clock and reset: clk rising edge; reset rst, synchronous, active-high.
- Reset values: `data_out`=0, `next_led_request`=0, `frame_done`=0, `busy`=0. State=RESET_WAIT, cycle counter=0, LED index=0, bit index=0.
- Reset mid-bit or mid-frame: line goes low on the next cycle and a full RESET_CYCLES low period restarts.
- States: RESET_WAIT, LOAD, SEND. All outputs are registered.
- RESET_WAIT:
  - `data_out`=0 and `next_led_request`=0.
  - Counts RESET_CYCLES cycles, then goes to LOAD.
- LOAD:
  - `data_out`=0.
  - If `color_valid`=1: latch the shift register as {green_in, red_in, blue_in} (GRB, green MSB first). Then:
    - `next_led_request` <= LED index+1 if LED index < NUM_LEDS-1, else 0.
    - Go to SEND with bit index=0 and cycle counter=0.
  - If `color_valid`=0: stay in LOAD and hold the line low (stall). The request is unchanged.
- Request prefetch: the request advances at LOAD. The colour source therefore has the full 24·BIT_CYCLES of SEND to settle before the next LOAD samples it.
- SEND, per bit:
  - `data_out`=1 for cycle counter < (bit ? T1H_CYCLES : T0H_CYCLES), else 0.
  - The counter wraps at BIT_CYCLES-1; on wrap the shift register shifts left and bit index increments.
- End of bit 23:
  - If LED index = NUM_LEDS-1: pulse `frame_done`, set LED index to 0, go to RESET_WAIT.
  - Otherwise: LED index+1, go to LOAD.
  - LOAD costs 1 extra low cycle between LEDs; this is within WS2812 tolerance.
- `color_valid` and colour inputs are ignored outside LOAD. Changes during SEND do not alter the bits in flight.
- NUM_LEDS=1: `next_led_request` stays 0 permanently.
- Widths:
  - Cycle counter sized to max(BIT_CYCLES, RESET_CYCLES).
  - LED index compare uses LED_ADDRESS_WIDTH bits.
  - Wrap to 0 is explicit; never rely on overflow.
- Parameter constraints: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; elaboration-time assertion.

Decomposition:
- Shared package `led_pkg`:
  - state enum {RESET_WAIT, LOAD, SEND};
  - default timing constants;
  - COLOR_BITS=24;
  - a GRB packing function.
- Sub-module `ws2812_bit_encoder`:
  - inputs: start, bit value;
  - outputs: line level and a bit_done pulse;
  - owns the per-bit cycle counter.
- The top owns the FSM, LED/bit indices, the shift register and the request output.

Test Plan:
Sim parameters for all scenarios: NUM_LEDS=3, T0H=2, T1H=4, BIT=6, RESET=10.
- Reset/latch period: release rst → `data_out`=0 and `busy`=0 for exactly 10 cycles, then LOAD samples request 0.
- Colour G=8'hA5, R=0, B=8'hFF held valid → waveform highs of 4,2,4,2,2,4,2,4 cycles for bits 1,0,1,0,0,1,0,1, then eight 2-cycle highs, then eight 4-cycle highs. Each bit is exactly 6 cycles.
- Request sequence over one frame:
  - `next_led_request` goes 0→1 at the first LOAD, 1→2 at the second, 2→0 at the third;
  - `frame_done` pulses once, at the end of bit 23 of LED 2;
  - then 10 low cycles follow.
- `color_valid` held 0 for 7 cycles at LOAD → line low, no state advance, request unchanged. SEND starts 1 cycle after `color_valid` rises.
- Colour inputs changed mid-SEND → transmitted bits match the value latched at LOAD.
- rst asserted in the middle of a high phase → `data_out`=0 next cycle, `next_led_request`=0, and a full 10-cycle low period before LED 0 is resent.
